clear_delay_ram: RTL and testbench
==================================

CLEAR_DELAY_RAM -- requirements
Module: clear_delay_ram

Interface
REQ-001 Parameter H_PIXELS, default 160: clear-scan width in pixels; legal range 1..256.
REQ-002 Parameter V_PIXELS, default 120: clear-scan height in lines; legal range 1..256.
REQ-003 Parameter DELAY_CYCLES, default 10008: enabled cycles counted before dly_finished asserts; legal range 1..65535.
REQ-004 clk  input  1  the single clock; every register samples on its rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset for all registers.
REQ-006 clr_enable  input  1  advances the clear scan while high.
REQ-007 clr_reset  input  1  synchronous restart of the clear scan; takes priority over clr_enable.
REQ-008 clr_x  output  8  current clear pixel column.
REQ-009 clr_y  output  8  current clear pixel row.
REQ-010 clr_color  output  12  clear pixel colour, RGB 4:4:4.
REQ-011 clr_finished  output  1  clear scan complete; sticky.
REQ-012 dly_enable  input  1  advances the delay counter while high.
REQ-013 dly_reset  input  1  synchronous restart of the delay counter; takes priority over dly_enable.
REQ-014 dly_finished  output  1  delay elapsed; sticky.
REQ-015 ram_wren  input  1  write strobe.
REQ-016 ram_wraddr  input  11  write address.
REQ-017 ram_wdata  input  8  write data.
REQ-018 ram_rden  input  1  read strobe.
REQ-019 ram_rdaddr  input  11  read address.
REQ-020 ram_q  output  8  registered read data.

Function
REQ-021 Clear engine: with clr_enable=1 and clr_finished=0, each cycle steps (clr_x, clr_y) in raster order.
- Column advance: clr_x increments; clr_x=H_PIXELS-1 wraps to 0 and increments clr_y.
REQ-022 clr_color shall be 12'h000 at all times.
REQ-023 Clear-scan end: from (H_PIXELS-1, V_PIXELS-1), the next enabled edge sets clr_finished=1 and holds clr_x and clr_y at those values.
- clr_finished stays 1 until clr_reset or rst_n.
- The scan takes exactly H_PIXELS*V_PIXELS enabled cycles (19200 at defaults).
REQ-024 clr_enable=0 freezes the clear scan position and clr_finished.
REQ-025 clr_reset=1 synchronously sets clr_x=0, clr_y=0 and clr_finished=0, whatever clr_enable is.
REQ-026 Delay engine: an internal 16-bit count increments on each edge with dly_enable=1 and dly_finished=0.
- When the count equals DELAY_CYCLES-1, the next enabled edge sets dly_finished=1.
- dly_finished therefore rises exactly DELAY_CYCLES enabled cycles after restart and stays 1 until dly_reset or rst_n.
- dly_enable=0 pauses the count.
REQ-027 dly_reset=1 synchronously clears the count and dly_finished.
REQ-028 RAM: 2048 x 8 simple dual-port array covering the full 11-bit address space, with no out-of-range addresses.
REQ-029 Write: on a clk edge with ram_wren=1, ram_wdata is stored at ram_wraddr.
REQ-030 Read: on a clk edge with ram_rden=1, ram_q loads mem[ram_rdaddr], giving 1-cycle read latency.
- ram_q holds its value while ram_rden=0.
REQ-031 Simultaneous read and write to the same address shall return the old data on ram_q; the new data is visible from the next read.
REQ-032 The clear engine, the delay engine and the RAM are independent; concurrent activity in one shall not affect the others.

Reset
REQ-033 While rst_n=0, immediately and independently of clk, the following outputs shall be 0:
- clr_x, clr_y, clr_finished
- the delay count and dly_finished
- ram_q
REQ-034 RAM array contents are not initialised by reset and are undefined until written.
REQ-035 Deasserting rst_n mid-operation shall restart both engines from 0.

Verification
REQ-036 Clear run: clr_enable=1 from reset -> cycle 0 at (0,0), cycle 159 at (159,0), cycle 160 at (0,1).
- clr_finished=1 after exactly 19200 edges, with the outputs then holding at (159,119).
REQ-037 Clear pause and restart: drop clr_enable at (10,5) for 20 cycles -> position frozen; then pulse clr_reset -> (0,0) with clr_finished=0.
REQ-038 Delay: DELAY_CYCLES=4, dly_enable=1 -> dly_finished rises on the 4th edge and holds; dly_reset -> dly_finished falls next edge.
REQ-039 RAM basic: write 8'hA5 to address 0 and 8'h3C to address 2047, then read each -> ram_q shows the data one cycle after the rden edge and holds with rden=0.
REQ-040 RAM collision: write 8'h11 to address 7, then in one cycle read and write 8'h22 at address 7 -> ram_q=8'h11; the following read gives 8'h22.
REQ-041 Async reset: assert rst_n=0 mid-scan between clk edges -> clr_x, clr_y, both finished flags and ram_q read 0 before the next clk edge.

Source files
------------

// File: rtl/clear_delay_ram_if.sv
// Bus bundle for clear_delay_ram: clear-scan, delay-timer and dual-port RAM signals.
// master drives the controls, slave (the block) drives the status and read data.
interface clear_delay_ram_if;
  logic        clr_enable;
  logic        clr_reset;
  logic [7:0]  clr_x;
  logic [7:0]  clr_y;
  logic [11:0] clr_color;
  logic        clr_finished;

  logic        dly_enable;
  logic        dly_reset;
  logic        dly_finished;

  logic        ram_wren;
  logic [10:0] ram_wraddr;
  logic [7:0]  ram_wdata;
  logic        ram_rden;
  logic [10:0] ram_rdaddr;
  logic [7:0]  ram_q;

  modport master (
    output clr_enable, clr_reset, dly_enable, dly_reset,
           ram_wren, ram_wraddr, ram_wdata, ram_rden, ram_rdaddr,
    input  clr_x, clr_y, clr_color, clr_finished, dly_finished, ram_q
  );

  modport slave (
    input  clr_enable, clr_reset, dly_enable, dly_reset,
           ram_wren, ram_wraddr, ram_wdata, ram_rden, ram_rdaddr,
    output clr_x, clr_y, clr_color, clr_finished, dly_finished, ram_q
  );
endinterface

// File: rtl/clear_delay_ram.sv
// Raster clear-scan generator, enable-gated delay timer and 2048x8 simple dual-port RAM.
// The three engines share only the clock and reset.
module clear_delay_ram #(
  parameter int unsigned H_PIXELS     = 160,
  parameter int unsigned V_PIXELS     = 120,
  parameter int unsigned DELAY_CYCLES = 10008
) (
  input logic               clk,
  input logic               rst_n,
  clear_delay_ram_if.slave  bus
);
  localparam int unsigned CW    = 8;
  localparam int unsigned DLYW  = 16;
  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 2048;

  localparam logic [CW-1:0]   X_LAST = CW'(H_PIXELS - 1);
  localparam logic [CW-1:0]   Y_LAST = CW'(V_PIXELS - 1);
  localparam logic [DLYW-1:0] D_LAST = DLYW'(DELAY_CYCLES - 1);

  logic [CW-1:0]   x, x_n, y, y_n;
  logic            clr_fin, clr_fin_n;
  logic [DLYW-1:0] cnt, cnt_n;
  logic            dly_fin, dly_fin_n;
  logic [DW-1:0]   mem [DEPTH];
  logic [DW-1:0]   q;

  // Clear scan: raster step, sticky at the last pixel once finished
  always_comb begin
    x_n       = x;
    y_n       = y;
    clr_fin_n = clr_fin;
    if (bus.clr_reset) begin
      x_n       = '0;
      y_n       = '0;
      clr_fin_n = 1'b0;
    end else if (bus.clr_enable && !clr_fin) begin
      if (x == X_LAST) begin
        if (y == Y_LAST) begin
          clr_fin_n = 1'b1;
        end else begin
          x_n = '0;
          y_n = y + CW'(1);
        end
      end else begin
        x_n = x + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x       <= '0;
      y       <= '0;
      clr_fin <= 1'b0;
    end else begin
      x       <= x_n;
      y       <= y_n;
      clr_fin <= clr_fin_n;
    end
  end

  // Delay timer: flag rises on the enabled edge that leaves count DELAY_CYCLES-1
  always_comb begin
    cnt_n     = cnt;
    dly_fin_n = dly_fin;
    if (bus.dly_reset) begin
      cnt_n     = '0;
      dly_fin_n = 1'b0;
    end else if (bus.dly_enable && !dly_fin) begin
      cnt_n = cnt + DLYW'(1);
      if (cnt == D_LAST) dly_fin_n = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      dly_fin <= 1'b0;
    end else begin
      cnt     <= cnt_n;
      dly_fin <= dly_fin_n;
    end
  end

  // Array is not reset; a same-address read returns the pre-write data
  always_ff @(posedge clk) begin
    if (bus.ram_wren) mem[bus.ram_wraddr] <= bus.ram_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (bus.ram_rden) begin
      q <= mem[bus.ram_rdaddr];
    end
  end

  assign bus.clr_x        = x;
  assign bus.clr_y        = y;
  assign bus.clr_color    = 12'h000;
  assign bus.clr_finished = clr_fin;
  assign bus.dly_finished = dly_fin;
  assign bus.ram_q        = q;
endmodule

// File: tb/tb_clear_delay_ram.sv
// Self-checking bench for clear_delay_ram: step-count reference model plus directed literal checks.
module tb_clear_delay_ram;
  localparam int unsigned H   = 160;
  localparam int unsigned V   = 120;
  localparam int unsigned HV  = H * V;
  localparam int unsigned DLY = 4;

  logic clk;
  logic rst_n;
  clear_delay_ram_if bus ();

  clear_delay_ram #(.H_PIXELS(H), .V_PIXELS(V), .DELAY_CYCLES(DLY)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_on   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: clear scan as a count of enabled steps, delay as a saturating count
  int unsigned n_clr;
  int unsigned n_dly;
  logic [7:0]  m_mem   [2048];
  bit          m_valid [2048];
  logic [7:0]  m_q;
  bit          q_known;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_clr   = 0;
      n_dly   = 0;
      m_q     = 8'h00;
      q_known = 1'b1;
    end else begin
      if (bus.clr_reset) n_clr = 0;
      else if (bus.clr_enable && n_clr < HV) n_clr++;
      if (bus.dly_reset) n_dly = 0;
      else if (bus.dly_enable && n_dly < DLY) n_dly++;
      if (bus.ram_rden) begin
        q_known = m_valid[bus.ram_rdaddr];
        if (q_known) m_q = m_mem[bus.ram_rdaddr];
      end
      if (bus.ram_wren) begin
        m_mem[bus.ram_wraddr]   = bus.ram_wdata;
        m_valid[bus.ram_wraddr] = 1'b1;
      end
    end
  end

  function automatic int unsigned exp_x(input int unsigned n);
    return (n >= HV) ? H - 1 : n % H;
  endfunction

  function automatic int unsigned exp_y(input int unsigned n);
    return (n >= HV) ? V - 1 : n / H;
  endfunction

  always @(negedge clk) begin
    if (chk_on && rst_n) begin
      check("cmp_clr_x",   32'(bus.clr_x),        exp_x(n_clr));
      check("cmp_clr_y",   32'(bus.clr_y),        exp_y(n_clr));
      check("cmp_clr_fin", 32'(bus.clr_finished), 32'(n_clr >= HV));
      check("cmp_color",   32'(bus.clr_color),    32'h0);
      check("cmp_dly_fin", 32'(bus.dly_finished), 32'(n_dly >= DLY));
      if (q_known) check("cmp_ram_q", 32'(bus.ram_q), 32'(m_q));
    end
  end

  task automatic edges(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [10:0] pick_addr();
    case ($urandom_range(0, 3))
      0:       return 11'd0;
      1:       return 11'd2047;
      default: return 11'($urandom_range(0, 15));
    endcase
  endfunction

  task automatic random_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.clr_enable = ($urandom_range(0, 3) != 0);
      bus.clr_reset  = ($urandom_range(0, 255) == 0);
      bus.dly_enable = ($urandom_range(0, 1) != 0);
      bus.dly_reset  = ($urandom_range(0, 15) == 0);
      bus.ram_wren   = ($urandom_range(0, 1) != 0);
      bus.ram_wraddr = pick_addr();
      bus.ram_wdata  = 8'($urandom);
      bus.ram_rden   = ($urandom_range(0, 1) != 0);
      bus.ram_rdaddr = pick_addr();
    end
  endtask

  task automatic idle_inputs();
    bus.clr_enable = 1'b0;
    bus.clr_reset  = 1'b0;
    bus.dly_enable = 1'b0;
    bus.dly_reset  = 1'b0;
    bus.ram_wren   = 1'b0;
    bus.ram_wraddr = '0;
    bus.ram_wdata  = '0;
    bus.ram_rden   = 1'b0;
    bus.ram_rdaddr = '0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    edges(3);
    check("rst_x",       32'(bus.clr_x),        32'd0);
    check("rst_y",       32'(bus.clr_y),        32'd0);
    check("rst_clr_fin", 32'(bus.clr_finished), 32'd0);
    check("rst_dly_fin", 32'(bus.dly_finished), 32'd0);
    check("rst_ram_q",   32'(bus.ram_q),        32'd0);

    // Full clear run from reset
    rst_n = 1'b1;
    chk_on = 1'b1;
    bus.clr_enable = 1'b1;
    check("run_c0_x", 32'(bus.clr_x), 32'd0);
    edges(159);
    check("run_c159_x", 32'(bus.clr_x), 32'd159);
    check("run_c159_y", 32'(bus.clr_y), 32'd0);
    edges(1);
    check("run_c160_x", 32'(bus.clr_x), 32'd0);
    check("run_c160_y", 32'(bus.clr_y), 32'd1);
    edges(19199 - 160);
    check("run_c19199_fin", 32'(bus.clr_finished), 32'd0);
    check("run_c19199_y",   32'(bus.clr_y),        32'd119);
    edges(1);
    check("run_c19200_fin", 32'(bus.clr_finished), 32'd1);
    edges(5);
    check("run_hold_x",   32'(bus.clr_x),        32'd159);
    check("run_hold_y",   32'(bus.clr_y),        32'd119);
    check("run_hold_fin", 32'(bus.clr_finished), 32'd1);

    // Pause at (10,5), then restart
    bus.clr_reset = 1'b1;
    edges(1);
    bus.clr_reset = 1'b0;
    edges(5 * 160 + 10);
    bus.clr_enable = 1'b0;
    edges(20);
    check("pause_x", 32'(bus.clr_x), 32'd10);
    check("pause_y", 32'(bus.clr_y), 32'd5);
    bus.clr_reset = 1'b1;
    edges(1);
    bus.clr_reset = 1'b0;
    check("restart_x",   32'(bus.clr_x),        32'd0);
    check("restart_y",   32'(bus.clr_y),        32'd0);
    check("restart_fin", 32'(bus.clr_finished), 32'd0);

    // Delay of 4 enabled edges
    bus.dly_enable = 1'b1;
    edges(3);
    check("dly_e3", 32'(bus.dly_finished), 32'd0);
    edges(1);
    check("dly_e4", 32'(bus.dly_finished), 32'd1);
    edges(3);
    check("dly_hold", 32'(bus.dly_finished), 32'd1);
    bus.dly_reset = 1'b1;
    edges(1);
    bus.dly_reset = 1'b0;
    bus.dly_enable = 1'b0;
    check("dly_clr", 32'(bus.dly_finished), 32'd0);

    // RAM basic at both address extremes
    bus.ram_wren = 1'b1; bus.ram_wraddr = 11'd0;    bus.ram_wdata = 8'hA5;
    edges(1);
    bus.ram_wraddr = 11'd2047; bus.ram_wdata = 8'h3C;
    edges(1);
    bus.ram_wren = 1'b0;
    bus.ram_rden = 1'b1; bus.ram_rdaddr = 11'd0;
    edges(1);
    check("ram_rd0", 32'(bus.ram_q), 32'hA5);
    bus.ram_rdaddr = 11'd2047;
    edges(1);
    check("ram_rd2047", 32'(bus.ram_q), 32'h3C);
    bus.ram_rden = 1'b0; bus.ram_rdaddr = 11'd0;
    edges(3);
    check("ram_hold", 32'(bus.ram_q), 32'h3C);

    // Same-address read/write collision returns the old data
    bus.ram_wren = 1'b1; bus.ram_wraddr = 11'd7; bus.ram_wdata = 8'h11;
    edges(1);
    bus.ram_wdata = 8'h22;
    bus.ram_rden = 1'b1; bus.ram_rdaddr = 11'd7;
    edges(1);
    check("ram_coll_old", 32'(bus.ram_q), 32'h11);
    bus.ram_wren = 1'b0;
    edges(1);
    check("ram_coll_new", 32'(bus.ram_q), 32'h22);
    idle_inputs();

    random_cycles(3000);

    // Build up non-zero state, then assert reset between edges
    @(negedge clk);
    idle_inputs();
    bus.clr_reset = 1'b1;
    bus.dly_reset = 1'b1;
    bus.ram_wren = 1'b1; bus.ram_wraddr = 11'd2047; bus.ram_wdata = 8'h3C;
    edges(1);
    bus.clr_reset = 1'b0;
    bus.dly_reset = 1'b0;
    bus.ram_wren = 1'b0;
    bus.clr_enable = 1'b1;
    bus.dly_enable = 1'b1;
    bus.ram_rden = 1'b1; bus.ram_rdaddr = 11'd2047;
    edges(1);
    bus.ram_rden = 1'b0;
    edges(50);
    check("pre_rst_x",       32'(bus.clr_x),        32'd51);
    check("pre_rst_dly_fin", 32'(bus.dly_finished), 32'd1);
    check("pre_rst_ram_q",   32'(bus.ram_q),        32'h3C);
    #2 rst_n = 1'b0;
    #1;
    check("arst_x",       32'(bus.clr_x),        32'd0);
    check("arst_y",       32'(bus.clr_y),        32'd0);
    check("arst_clr_fin", 32'(bus.clr_finished), 32'd0);
    check("arst_dly_fin", 32'(bus.dly_finished), 32'd0);
    check("arst_ram_q",   32'(bus.ram_q),        32'd0);
    edges(2);
    rst_n = 1'b1;
    check("post_rst_x", 32'(bus.clr_x), 32'd0);
    edges(10);
    check("post_rst_run_x", 32'(bus.clr_x), 32'd10);

    random_cycles(1000);
    edges(1);
    chk_on = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
